// File: rtl/ripple_carry_adder_sync.sv
// Registered signed adder built from an explicit ripple chain of full-adder stages.
// Define RCA_OVERFLOW_FLAG_EN to add a registered signed-overflow output.
module ripple_carry_adder_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             out_valid
`ifdef RCA_OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = c_in;

  // One full adder per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    assign sum[i]     = op1[i] ^ op2[i] ^ carry[i];
    assign carry[i+1] = (op1[i] & op2[i]) | (op1[i] & carry[i]) | (op2[i] & carry[i]);
  end

  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d;
  logic             out_valid_q, out_valid_d;

  always_comb begin
    result_d    = result_q;
    c_out_d     = c_out_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      result_d = sum;
      c_out_d  = carry[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign c_out     = c_out_q;
  assign out_valid = out_valid_q;

`ifdef RCA_OVERFLOW_FLAG_EN
  logic overflow_q, overflow_d;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    overflow_d = overflow_q;
    if (in_valid) overflow_d = carry[WIDTH] ^ carry[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_ripple_carry_adder_sync.sv
// Self-checking bench for ripple_carry_adder_sync: directed corner cases plus a
// randomized stream compared against an arithmetic reference model.
module tb_ripple_carry_adder_sync;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] op1, op2;
  logic         c_in;
  logic [W-1:0] result;
  logic         c_out;
  logic         out_valid;
`ifdef RCA_OVERFLOW_FLAG_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs should hold after the next edge.
  int exp_res = 0;
  int exp_co  = 0;
  int exp_vld = 0;
  int exp_ov  = 0;

  ripple_carry_adder_sync #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .op1      (op1),
    .op2      (op2),
    .c_in     (c_in),
    .result   (result),
    .c_out    (c_out),
`ifdef RCA_OVERFLOW_FLAG_EN
    .overflow (overflow),
`endif
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Update the model from the inputs about to be sampled, clock once, compare.
  task automatic step(input string tag);
    int ua, ub, usum, sa, sb, ssum;
    if (rst) begin
      exp_res = 0; exp_co = 0; exp_vld = 0; exp_ov = 0;
    end else if (in_valid) begin
      ua   = int'(op1);
      ub   = int'(op2);
      usum = ua + ub + int'(c_in);
      sa   = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
      sb   = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
      ssum = sa + sb + int'(c_in);
      exp_res = usum % (1 << W);
      exp_co  = (usum >> W) & 1;
      exp_vld = 1;
      exp_ov  = (ssum > (1 << (W-1)) - 1 || ssum < -(1 << (W-1))) ? 1 : 0;
    end else begin
      exp_vld = 0;
    end
    @(posedge clk);
    #1;
    check({tag, ".result"},    64'(result),    64'(exp_res));
    check({tag, ".c_out"},     64'(c_out),     64'(exp_co));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_vld));
`ifdef RCA_OVERFLOW_FLAG_EN
    check({tag, ".overflow"},  64'(overflow),  64'(exp_ov));
`endif
  endtask

  task automatic drive(input logic r, input logic v, input int a, input int b, input logic ci);
    rst      = r;
    in_valid = v;
    op1      = W'(a);
    op2      = W'(b);
    c_in     = ci;
  endtask

  initial begin
    drive(1'b1, 1'b1, 5, 2, 1'b0);
    step("reset0");
    step("reset1");

    drive(1'b0, 1'b1, 3, 4, 1'b0);
    step("basic");
    check("basic.const_sum", 64'(result), 64'd7);
    drive(1'b0, 1'b0, 9, 9, 1'b1);
    step("hold");
    check("hold.const_sum", 64'(result), 64'd7);

    drive(1'b0, 1'b1, -1, 1, 1'b0);
    step("wrap_m1p1");
    drive(1'b0, 1'b1, -8, -8, 1'b1);
    step("m8m8c1");
    check("m8m8c1.const", 64'({c_out, result}), 64'h11);
    drive(1'b0, 1'b1, 7, 1, 1'b0);
    step("ovf_7p1");
    check("ovf_7p1.const", 64'({c_out, result}), 64'h08);
    drive(1'b0, 1'b1, -1, -1, 1'b1);
    step("m1m1c1");
    check("m1m1c1.const", 64'({c_out, result}), 64'h1f);

    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 1'b1, int'($urandom_range(0, (1 << W) - 1)),
            int'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)));
      if (i == 25) begin
        rst = 1'b1;
        step("stream_rst");
        rst = 1'b0;
      end else begin
        step("stream");
      end
    end

    drive(1'b0, 1'b0, 0, 0, 1'b0);
    step("idle_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit 100000 ns");
    $fatal(1);
  end

endmodule

// File: doc/ripple_carry_adder_sync.md
Name:
ripple_carry_adder_sync

Overview:
- Registered signed two's-complement adder: sum = op1 + op2 + c_in, computed by an explicit bit-level ripple chain of full-adder stages.
- Result, carry-out and valid are registered, one cycle after inputs are sampled.
- Used as the adder slice of the ALU datapath.
- Default width is 4 bits; the width is parameterised.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2 to 64).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, qualifies op1/op2/c_in for capture this cycle.
- op1, input, WIDTH, signed two's-complement operand A.
- op2, input, WIDTH, signed two's-complement operand B.
- c_in, input, 1, carry into bit 0.
- result, output, WIDTH, signed sum bits [WIDTH-1:0], registered.
- c_out, output, 1, carry out of bit WIDTH-1, registered.
- out_valid, output, 1, high for one cycle when result/c_out hold a newly captured sum.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Combinational core:
  - Stage i is a full adder: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i].
  - c[0] = c_in.
  - The core is built with a generate loop of WIDTH stages. No behavioural '+' operator.
- Arithmetic: {c_out, result} == zero-extended op1 + zero-extended op2 + c_in, modulo 2^(WIDTH+1).
  - result is interpreted as signed.
  - c_out is the unsigned carry. It is not a signed overflow indicator.
- Capture and latency: on a rising clk edge with rst=0 and in_valid=1:
  - result <= s and c_out <= c[WIDTH].
  - out_valid <= 1.
  - Latency is exactly 1 cycle. Back-to-back in_valid is accepted every cycle; there is no backpressure.
- Idle: on a rising edge with rst=0 and in_valid=0, result and c_out hold their previous values and out_valid <= 0.
- Reset: on a rising edge with rst=1, result <= 0, c_out <= 0, out_valid <= 0 (and overflow <= 0 when compiled in).
  - Reset takes priority over in_valid.
  - An operation presented in the reset cycle is discarded.
  - Outputs are undefined only before the first reset edge.
- X/metastability: the inputs are synchronous to clk. There are no internal state machines beyond the output registers.
- Boundary wraps for WIDTH=4:
  - 7+1+0 -> result -8 (1000), c_out 0.
  - -1+1+0 -> result 0, c_out 1.
  - -1+-1+1 -> result -1, c_out 1.

Optional Feature:
- Macro: RCA_OVERFLOW_FLAG_EN.
- When defined:
  - Adds output port overflow (1 bit), registered alongside result.
  - overflow <= c[WIDTH] ^ c[WIDTH-1], i.e. signed two's-complement overflow.
  - overflow holds when in_valid=0 and resets to 0.
- When undefined:
  - The port does not exist and no overflow logic is synthesised.
  - All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, op1=5, op2=2 -> result=0, c_out=0, out_valid=0 after each edge.
- Basic sum: op1=3, op2=4, c_in=0, in_valid=1 -> next cycle result=7, c_out=0, out_valid=1. With in_valid=0 the following cycle -> values hold, out_valid=0.
- Carry/wrap: op1=-1, op2=1, c_in=0 -> result=0, c_out=1. Then op1=-8, op2=-8, c_in=1 -> result=1, c_out=1, overflow=1 if enabled.
- Signed overflow: op1=7, op2=1, c_in=0 -> result=-8, c_out=0, overflow=1 if enabled. Also op1=-1, op2=-1, c_in=1 -> result=-1, c_out=1, overflow=0.
- Streaming: 50 consecutive cycles of random op1/op2/c_in with in_valid=1 -> each cycle's outputs equal a golden model of the previous cycle's inputs, out_valid held at 1.
- Reset mid-stream: assert rst for one cycle during the random stream -> outputs zero the next cycle; the first post-reset in_valid sample appears exactly 1 cycle later.
